// File: rtl/j11_busresp.sv
// -----------------------------------------------------------------------------
// j11_busresp
//
// Bus responder for the DCJ11 front end. Serves the single-request memory bus
// issued by the CPU interface and returns exactly one busack per busreq, two
// cycles after the request. Each request goes to one of these targets:
//   - GP space (busgp=1): reads return PUCFG, writes are discarded.
//   - I/O page (busaddr[21:13] all ones): DL11-style console registers
//     RCSR/RBUF/XCSR/XBUF at 17777560..17777566 and the switch/display
//     register at 17777570 (octal byte addresses).
//   - On-chip RAM of 2^MEMW_LOG2 words, mapped from byte address 0.
//   - Anything else: reads return 0, writes are ignored.
// Also bridges the console byte streams and drives the CPU interrupt lines.
//
// Parameters:
//   MEMW_LOG2 : log2 of the RAM size in 16-bit words
//   PUCFG     : data returned by every GP read
//
// Ports:
//   clk      in   system clock
//   rstn     in   asynchronous active-low reset
//   busreq   in   one-cycle request pulse (qualifies the next four inputs)
//   buswr    in   1 = write, 0 = read
//   busgp    in   GP cycle, address not decoded
//   busaddr  in   22-bit byte address (bit 0 ignored)
//   buswdata in   16-bit write data
//   busack   out  one-cycle completion pulse
//   busrdata out  read data, valid while busack=1 (0 otherwise)
//   rxdata/rxvalid in, rxready out : console receive stream
//   txdata/txvalid out, txready in : console transmit stream
//   sw       in   switch register
//   disp     out  display register
//   irq      out  interrupt lines, bit 0 = console, bits 3:1 tied to 0
// -----------------------------------------------------------------------------
module j11_busresp #(
  parameter int          MEMW_LOG2 = 15,
  parameter logic [15:0] PUCFG     = 16'hF604
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        busreq,
  input  logic        buswr,
  input  logic        busgp,
  input  logic [21:0] busaddr,
  input  logic [15:0] buswdata,
  output logic        busack,
  output logic [15:0] busrdata,
  input  logic [7:0]  rxdata,
  input  logic        rxvalid,
  output logic        rxready,
  output logic [7:0]  txdata,
  output logic        txvalid,
  input  logic        txready,
  input  logic [15:0] sw,
  output logic [15:0] disp,
  output logic [3:0]  irq
);

  // ---------------------------------------------------------------------------
  // Address map
  // ---------------------------------------------------------------------------
  localparam logic [21:0] A_RCSR = 22'o17777560;
  localparam logic [21:0] A_RBUF = 22'o17777562;
  localparam logic [21:0] A_XCSR = 22'o17777564;
  localparam logic [21:0] A_XBUF = 22'o17777566;
  localparam logic [21:0] A_SWR  = 22'o17777570;

  localparam int          RAM_DEPTH = 1 << MEMW_LOG2;
  localparam logic [21:0] RAM_WORDS = 22'(RAM_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_ACK
  } state_t;

  typedef enum logic [2:0] {
    TGT_GP,
    TGT_RCSR,
    TGT_RBUF,
    TGT_XCSR,
    TGT_XBUF,
    TGT_SWR,
    TGT_RAM,
    TGT_NONE
  } target_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t      r_state;

  // Latched request (busaddr bit 0 is never stored: the bus is word-wide).
  logic        r_wr;
  logic        r_gp;
  logic [21:1] r_addr;
  logic [15:0] r_wdata;

  // Bus response
  logic        r_ack;
  logic [15:0] r_rdata;    // register / GP read data, captured in ACCESS
  logic        r_sel_ram;  // ACK cycle returns the RAM output instead

  // Console and switch/display registers
  logic        r_done;
  logic        r_rie;
  logic        r_xie;
  logic [7:0]  r_rbuf;
  logic        r_txvalid;
  logic [7:0]  r_txdata;
  logic [15:0] r_disp;
  logic [3:0]  r_irq;

  // RAM
  logic [15:0] r_mem [0:RAM_DEPTH-1];
  logic [15:0] r_ram_q;

  // Decode of the latched request
  target_t              w_tgt;
  logic [15:0]          w_rd_reg;
  logic                 w_io_page;
  logic                 w_ram_hit;
  logic [MEMW_LOG2-1:0] w_ram_idx;
  logic                 w_ram_we;
  logic                 w_unused;

  assign w_unused  = busaddr[0];
  assign w_io_page = &r_addr[21:13];
  assign w_ram_hit = ({1'b0, r_addr} < RAM_WORDS);
  assign w_ram_idx = r_addr[MEMW_LOG2:1];

  // Target decode in priority order: GP, I/O page, RAM, unmapped.
  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_tgt = TGT_NONE;
    if (r_gp) begin
      w_tgt = TGT_GP;
    end else if (w_io_page) begin
      if      (r_addr == A_RCSR[21:1]) w_tgt = TGT_RCSR;
      else if (r_addr == A_RBUF[21:1]) w_tgt = TGT_RBUF;
      else if (r_addr == A_XCSR[21:1]) w_tgt = TGT_XCSR;
      else if (r_addr == A_XBUF[21:1]) w_tgt = TGT_XBUF;
      else if (r_addr == A_SWR[21:1])  w_tgt = TGT_SWR;
    end else if (w_ram_hit) begin
      w_tgt = TGT_RAM;
    end
  end

  // Read data for every non-RAM target; RAM data comes straight from the
  // block-RAM output register in the ACK cycle.
  always_comb begin
    w_rd_reg = 16'h0000;
    case (w_tgt)
      TGT_GP:   w_rd_reg = PUCFG;
      TGT_RCSR: w_rd_reg = {8'h00, r_done, r_rie, 6'b000000};
      TGT_RBUF: w_rd_reg = {8'h00, r_rbuf};
      TGT_XCSR: w_rd_reg = {8'h00, !r_txvalid, r_xie, 6'b000000};
      TGT_SWR:  w_rd_reg = sw;
      default:  w_rd_reg = 16'h0000;
    endcase
  end

  // The write is gated by the live FSM state, so a reset arriving during
  // ACCESS forces IDLE and suppresses the RAM write at the next edge.
  assign w_ram_we = (r_state == ST_ACCESS) && (w_tgt == TGT_RAM) && r_wr;

  // ---------------------------------------------------------------------------
  // RAM: one synchronous write port, registered read (block-RAM style).
  // NOTE: the memory array and its output register have no reset so the
  // array maps onto block RAM; their contents are undefined after reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_mem[w_ram_idx] <= r_wdata;
    end
    r_ram_q <= r_mem[w_ram_idx];
  end

  // ---------------------------------------------------------------------------
  // Bus FSM, console registers and interrupt.
  // NOTE: all state here uses non-blocking assignments; a later assignment to
  // the same register in this block overrides an earlier one in the same
  // cycle, which the receive path below relies on.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_wr      <= 1'b0;
      r_gp      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= 16'h0000;
      r_ack     <= 1'b0;
      r_rdata   <= 16'h0000;
      r_sel_ram <= 1'b0;
      r_done    <= 1'b0;
      r_rie     <= 1'b0;
      r_xie     <= 1'b0;
      r_rbuf    <= 8'h00;
      r_txvalid <= 1'b0;
      r_txdata  <= 8'h00;
      r_disp    <= 16'h0000;
      r_irq     <= 4'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ack     <= 1'b0;
          r_rdata   <= 16'h0000;
          r_sel_ram <= 1'b0;
          if (busreq) begin
            r_wr    <= buswr;
            r_gp    <= busgp;
            r_addr  <= busaddr[21:1];
            r_wdata <= buswdata;
            r_state <= ST_ACCESS;
          end
        end

        ST_ACCESS: begin
          r_ack     <= 1'b1;
          r_rdata   <= r_wr ? 16'h0000 : w_rd_reg;
          r_sel_ram <= (w_tgt == TGT_RAM) && !r_wr;
          if (r_wr) begin
            case (w_tgt)
              TGT_RCSR: r_rie  <= r_wdata[6];
              TGT_XCSR: r_xie  <= r_wdata[6];
              TGT_SWR:  r_disp <= r_wdata;
              TGT_XBUF: begin
                // READY is !txvalid; a write while busy (including the cycle
                // the transmit handshake completes) is dropped.
                if (!r_txvalid) begin
                  r_txvalid <= 1'b1;
                  r_txdata  <= r_wdata[7:0];
                end
              end
              default: ;
            endcase
          end else if (w_tgt == TGT_RBUF) begin
            r_done <= 1'b0;
          end
          r_state <= ST_ACCESS == ST_ACCESS ? ST_ACK : ST_IDLE;
        end

        ST_ACK: begin
          r_ack     <= 1'b0;
          r_rdata   <= 16'h0000;
          r_sel_ram <= 1'b0;
          r_state   <= ST_IDLE;
        end

        default: begin
          r_ack   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase

      // Receive handshake. Placed after the bus side effects so a new byte
      // wins over an RBUF read clearing DONE in the same cycle.
      if (rxvalid && !r_done) begin
        r_rbuf <= rxdata;
        r_done <= 1'b1;
      end

      // Transmit handshake; txdata holds its value.
      if (r_txvalid && txready) begin
        r_txvalid <= 1'b0;
      end

      // Level interrupt, one cycle behind the register state.
      r_irq <= {3'b000, (r_done && r_rie) || (!r_txvalid && r_xie)};
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busack   = r_ack;
  assign busrdata = r_sel_ram ? r_ram_q : r_rdata;
  assign rxready  = !r_done;
  assign txvalid  = r_txvalid;
  assign txdata   = r_txdata;
  assign disp     = r_disp;
  assign irq      = r_irq;

endmodule
